usb_desc_ctrl: RTL
==================

USB_DESC_CTRL -- requirements
Module: usb_desc_ctrl

Interface
REQ-001 SHALL have parameter MAXPKT, default 64, EP0 max packet size in bytes (8, 16, 32 or 64).
REQ-002 SHALL have port CLK, input, 1, single clock for all logic.
REQ-003 SHALL have port RESETN, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port i_req, input, 1, one-cycle GET_DESCRIPTOR request strobe.
REQ-005 SHALL have ports i_desc_type, input, 8 (wValue high) and i_desc_idx, input, 8 (wValue low).
REQ-006 SHALL have port i_wlength, input, 16, host-requested length.
REQ-007 SHALL have port i_hs_mode, input, 1, device currently enumerated at high speed.
REQ-008 SHALL have inputs for the descriptor map (all 16 bits): dev/qual/fscfg/hscfg addr+len, oscfg addr, strlang addr, strvendor/strproduct/strserial addr+len. SHALL also have i_have_strings (1).
REQ-009 SHALL have port o_descrom_raddr, output, 16, ROM read address; SHALL have port i_descrom_rdat, input, 8, asynchronous-read ROM data.
REQ-010 SHALL have port i_in_token, input, 1, one-cycle pulse granting one IN data packet.
REQ-011 SHALL have ports o_txdat (output, 8), o_txval (output, 1), i_txrdy (input, 1), o_txlast (output, 1) and o_txzlp (output, 1).
REQ-012 SHALL have ports o_busy, o_done and o_stall, each output, 1.
REQ-013 SHALL have port i_abort, input, 1, new SETUP received; cancels the current transfer.

Function
REQ-014 SHALL implement states IDLE, LOOKUP, WAIT_IN, SEND, ZLP, DONE and STALL.
REQ-015 IDLE: i_req SHALL latch type, idx and wLength, then go to LOOKUP; i_req outside IDLE SHALL be ignored.
REQ-016 LOOKUP (exactly 1 cycle) SHALL select base/len as follows:
- type 1: dev.
- type 6: qual.
- type 2: hscfg if i_hs_mode, else fscfg.
- type 7: the opposite-speed config of type 2.
- type 3 idx 0: strlang, len 4; idx 1/2/3: vendor/product/serial.
REQ-017 Type 3 with !i_have_strings or idx>3, any other type, or selected len 0 SHALL go to STALL.
REQ-018 Total SHALL equal min(len, wLength) in 16-bit unsigned arithmetic; total==0 SHALL go directly to DONE.
REQ-019 WAIT_IN: i_in_token SHALL start a packet of pkt = min(remaining, MAXPKT) bytes and go to SEND.
REQ-020 SEND: o_descrom_raddr SHALL equal base+offset and o_txdat SHALL equal i_descrom_rdat with o_txval=1. The offset SHALL advance only on o_txval&&i_txrdy.
REQ-021 For type 7, the byte at offset 1 SHALL be driven as 8'h07 instead of the ROM data.
REQ-022 o_txlast SHALL be 1 on the final byte of each packet. After that byte's handshake:
- remaining>0 -> WAIT_IN.
- remaining==0 and total%MAXPKT==0 and total<wLength -> ZLP.
- otherwise -> DONE.
REQ-023 ZLP: the next i_in_token SHALL cause o_txzlp=1 with o_txval=0 for 1 cycle, then DONE.
REQ-024 DONE SHALL pulse o_done for 1 cycle and return to IDLE.
REQ-025 STALL SHALL hold o_stall=1 until i_abort or the next i_req.
REQ-026 o_busy SHALL be 1 in every state except IDLE.
REQ-027 i_abort in any state SHALL force IDLE next cycle, with o_txval, o_txlast and o_txzlp forced low the same cycle and no o_done. i_abort SHALL take priority over a simultaneous i_in_token, i_txrdy or i_req.
REQ-028 i_in_token arriving during SEND, ZLP, LOOKUP or DONE SHALL be ignored.
REQ-029 o_txdat SHALL be stable while o_txval=1 and i_txrdy=0.

Reset
REQ-030 RESETN low SHALL asynchronously force state IDLE, offset/remaining/total to 0 and all outputs to 0, including o_descrom_raddr=0.
REQ-031 Reset deassertion SHALL be synchronised internally; the first i_req SHALL be accepted no earlier than the 2nd CLK edge after RESETN rises.

Verification
REQ-032 Type 1, wLength=64, MAXPKT=64, one IN -> 18 bytes starting 12 01, o_txlast on byte 17, no ZLP, o_done pulse.
REQ-033 Type 2, FS, wLength=9 -> single 9-byte packet 09 02 27 00 01 01 00 80 FA, then o_done.
REQ-034 Type 7, i_hs_mode=1, wLength=255 -> 39 bytes of fscfg, byte1=07; with MAXPKT=8 -> packets 8,8,8,8,7, each waiting for i_in_token.
REQ-035 Type 3 idx 0, MAXPKT=4 (ZLP case) -> packet 04 03 09 04, then a 1-cycle o_txzlp on the next IN. Type 3 idx 0, wLength=4 -> no ZLP.
REQ-036 Type 0x22, or type 3 idx 5 -> o_stall=1, no o_txval, until the next i_req.
REQ-037 i_abort on byte 5 with i_txrdy held low (backpressure) -> o_txval=0 next cycle, IDLE, no o_done; a new i_req is then served correctly.

Source files
------------

// File: rtl/usb_desc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : usb_desc_ctrl_if
// Brief    : Bundle that connects the GET_DESCRIPTOR engine to its
//            surroundings. It carries the request fields, the descriptor
//            map, the ROM read port, the IN data stream and the status
//            outputs.
// Revision : 1.0  initial release
// ============================================================================
interface usb_desc_ctrl_if;
    // request
    logic        i_req;
    logic [7:0]  i_desc_type;
    logic [7:0]  i_desc_idx;
    logic [15:0] i_wlength;
    logic        i_hs_mode;
    // descriptor map
    logic [15:0] i_dev_addr;
    logic [15:0] i_dev_len;
    logic [15:0] i_qual_addr;
    logic [15:0] i_qual_len;
    logic [15:0] i_fscfg_addr;
    logic [15:0] i_fscfg_len;
    logic [15:0] i_hscfg_addr;
    logic [15:0] i_hscfg_len;
    logic [15:0] i_oscfg_addr;
    logic [15:0] i_strlang_addr;
    logic [15:0] i_strvendor_addr;
    logic [15:0] i_strvendor_len;
    logic [15:0] i_strproduct_addr;
    logic [15:0] i_strproduct_len;
    logic [15:0] i_strserial_addr;
    logic [15:0] i_strserial_len;
    logic        i_have_strings;
    // descriptor ROM
    logic [15:0] o_descrom_raddr;
    logic [7:0]  i_descrom_rdat;
    // IN data stream
    logic        i_in_token;
    logic [7:0]  o_txdat;
    logic        o_txval;
    logic        i_txrdy;
    logic        o_txlast;
    logic        o_txzlp;
    // status / control
    logic        o_busy;
    logic        o_done;
    logic        o_stall;
    logic        i_abort;

    // descriptor engine side
    modport slave (
        input  i_req, i_desc_type, i_desc_idx, i_wlength, i_hs_mode,
        input  i_dev_addr, i_dev_len, i_qual_addr, i_qual_len,
        input  i_fscfg_addr, i_fscfg_len, i_hscfg_addr, i_hscfg_len,
        input  i_oscfg_addr, i_strlang_addr,
        input  i_strvendor_addr, i_strvendor_len,
        input  i_strproduct_addr, i_strproduct_len,
        input  i_strserial_addr, i_strserial_len, i_have_strings,
        output o_descrom_raddr,
        input  i_descrom_rdat,
        input  i_in_token,
        output o_txdat, o_txval, o_txlast, o_txzlp,
        input  i_txrdy,
        output o_busy, o_done, o_stall,
        input  i_abort
    );

    // control-endpoint / ROM side
    modport master (
        output i_req, i_desc_type, i_desc_idx, i_wlength, i_hs_mode,
        output i_dev_addr, i_dev_len, i_qual_addr, i_qual_len,
        output i_fscfg_addr, i_fscfg_len, i_hscfg_addr, i_hscfg_len,
        output i_oscfg_addr, i_strlang_addr,
        output i_strvendor_addr, i_strvendor_len,
        output i_strproduct_addr, i_strproduct_len,
        output i_strserial_addr, i_strserial_len, i_have_strings,
        input  o_descrom_raddr,
        output i_descrom_rdat,
        output i_in_token,
        input  o_txdat, o_txval, o_txlast, o_txzlp,
        output i_txrdy,
        input  o_busy, o_done, o_stall,
        output i_abort
    );
endinterface
`default_nettype wire

// File: rtl/usb_desc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : usb_desc_ctrl
// Brief    : EP0 GET_DESCRIPTOR engine. Looks up a descriptor in the map,
//            clips it to wLength and streams it from the descriptor ROM in
//            MAXPKT-sized IN packets, adding a ZLP when the host must be
//            told that a short transfer ended on a packet boundary.
// Revision : 1.0  initial release
// ============================================================================
module usb_desc_ctrl #(
    parameter int MAXPKT = 64
) (
    input  wire             CLK,
    input  wire             RESETN,
    usb_desc_ctrl_if.slave  bus
);

    localparam logic [15:0] c_maxpkt   = 16'(MAXPKT);
    localparam logic [15:0] c_pkt_mask = 16'(MAXPKT - 1);
    localparam logic [15:0] c_lang_len = 16'd4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_WAIT_IN = 3'd2,
        S_SEND    = 3'd3,
        S_ZLP     = 3'd4,
        S_DONE    = 3'd5,
        S_STALL   = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // reset synchroniser: asserts immediately, releases after two edges
    // ------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    // two-flop release chain for the internal reset
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // ------------------------------------------------------------------
    // state and datapath registers
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_type;
    logic [7:0]  r_idx;
    logic [15:0] r_wlength;
    logic [15:0] r_base;
    logic [15:0] r_total;
    logic [15:0] r_remaining;
    logic [15:0] r_offset;
    logic [15:0] r_pkt_left;

    // lookup results
    logic [15:0] w_sel_base;
    logic [15:0] w_sel_len;
    logic        w_sel_ok;
    logic [15:0] w_total;
    logic [15:0] w_pkt;
    logic        w_fire;
    logic        w_zlp_due;

    // descriptor map decode from the latched request fields
    always_comb begin
        w_sel_base = 16'd0;
        w_sel_len  = 16'd0;
        w_sel_ok   = 1'b0;
        case (r_type)
            8'h01: begin
                w_sel_base = bus.i_dev_addr;
                w_sel_len  = bus.i_dev_len;
                w_sel_ok   = 1'b1;
            end
            8'h06: begin
                w_sel_base = bus.i_qual_addr;
                w_sel_len  = bus.i_qual_len;
                w_sel_ok   = 1'b1;
            end
            8'h02: begin
                w_sel_base = bus.i_hs_mode ? bus.i_hscfg_addr : bus.i_fscfg_addr;
                w_sel_len  = bus.i_hs_mode ? bus.i_hscfg_len  : bus.i_fscfg_len;
                w_sel_ok   = 1'b1;
            end
            8'h07: begin
                // other-speed configuration: the config of the speed we are not running at
                w_sel_base = bus.i_hs_mode ? bus.i_fscfg_addr : bus.i_hscfg_addr;
                w_sel_len  = bus.i_hs_mode ? bus.i_fscfg_len  : bus.i_hscfg_len;
                w_sel_ok   = 1'b1;
            end
            8'h03: begin
                if (bus.i_have_strings) begin
                    case (r_idx)
                        8'd0: begin
                            w_sel_base = bus.i_strlang_addr;
                            w_sel_len  = c_lang_len;
                            w_sel_ok   = 1'b1;
                        end
                        8'd1: begin
                            w_sel_base = bus.i_strvendor_addr;
                            w_sel_len  = bus.i_strvendor_len;
                            w_sel_ok   = 1'b1;
                        end
                        8'd2: begin
                            w_sel_base = bus.i_strproduct_addr;
                            w_sel_len  = bus.i_strproduct_len;
                            w_sel_ok   = 1'b1;
                        end
                        8'd3: begin
                            w_sel_base = bus.i_strserial_addr;
                            w_sel_len  = bus.i_strserial_len;
                            w_sel_ok   = 1'b1;
                        end
                        default: w_sel_ok = 1'b0;
                    endcase
                end
            end
            default: w_sel_ok = 1'b0;
        endcase
    end

    assign w_total   = (w_sel_len < r_wlength) ? w_sel_len : r_wlength;
    assign w_pkt     = (r_remaining < c_maxpkt) ? r_remaining : c_maxpkt;
    assign w_fire    = (r_state == S_SEND) && bus.i_txrdy;
    // a short-but-aligned transfer needs an explicit zero-length terminator
    assign w_zlp_due = ((r_total & c_pkt_mask) == 16'd0) && (r_total < r_wlength);

    // state register
    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state decode; abort overrides every other event
    always_comb begin
        w_state_nxt = r_state;
        if (bus.i_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_req) w_state_nxt = S_LOOKUP;
                end
                S_LOOKUP: begin
                    if (!w_sel_ok || (w_sel_len == 16'd0)) w_state_nxt = S_STALL;
                    else if (w_total == 16'd0)             w_state_nxt = S_DONE;
                    else                                    w_state_nxt = S_WAIT_IN;
                end
                S_WAIT_IN: begin
                    if (bus.i_in_token) w_state_nxt = S_SEND;
                end
                S_SEND: begin
                    if (w_fire && (r_pkt_left == 16'd1)) begin
                        if (r_remaining != 16'd1) w_state_nxt = S_WAIT_IN;
                        else if (w_zlp_due)       w_state_nxt = S_ZLP;
                        else                      w_state_nxt = S_DONE;
                    end
                end
                S_ZLP: begin
                    if (bus.i_in_token) w_state_nxt = S_DONE;
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                S_STALL: begin
                    // a fresh request is the host's way out of a stall
                    if (bus.i_req) w_state_nxt = S_LOOKUP;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // request latch, lookup capture and byte/packet counters
    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_type      <= 8'd0;
            r_idx       <= 8'd0;
            r_wlength   <= 16'd0;
            r_base      <= 16'd0;
            r_total     <= 16'd0;
            r_remaining <= 16'd0;
            r_offset    <= 16'd0;
            r_pkt_left  <= 16'd0;
        end else if (bus.i_abort) begin
            r_total     <= 16'd0;
            r_remaining <= 16'd0;
            r_offset    <= 16'd0;
            r_pkt_left  <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE, S_STALL: begin
                    if (bus.i_req) begin
                        r_type    <= bus.i_desc_type;
                        r_idx     <= bus.i_desc_idx;
                        r_wlength <= bus.i_wlength;
                    end
                end
                S_LOOKUP: begin
                    r_base      <= w_sel_base;
                    r_total     <= w_total;
                    r_remaining <= w_total;
                    r_offset    <= 16'd0;
                end
                S_WAIT_IN: begin
                    if (bus.i_in_token) r_pkt_left <= w_pkt;
                end
                S_SEND: begin
                    if (w_fire) begin
                        r_offset    <= r_offset + 16'd1;
                        r_remaining <= r_remaining - 16'd1;
                        r_pkt_left  <= r_pkt_left - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // outputs: decoded from state so reset drives them all to zero
    // ------------------------------------------------------------------
    logic w_sending;
    assign w_sending = (r_state == S_SEND) && !bus.i_abort;

    // address is held for the whole byte so ROM data stays stable under backpressure
    assign bus.o_descrom_raddr = (r_state == S_SEND) ? (r_base + r_offset) : 16'd0;
    assign bus.o_txdat  = !w_sending                                  ? 8'h00 :
                          ((r_type == 8'h07) && (r_offset == 16'd1))  ? 8'h07 :
                                                                        bus.i_descrom_rdat;
    assign bus.o_txval  = w_sending;
    assign bus.o_txlast = w_sending && (r_pkt_left == 16'd1);
    assign bus.o_txzlp  = (r_state == S_ZLP) && bus.i_in_token && !bus.i_abort;
    assign bus.o_busy   = (r_state != S_IDLE);
    assign bus.o_done   = (r_state == S_DONE) && !bus.i_abort;
    assign bus.o_stall  = (r_state == S_STALL);

endmodule
`default_nettype wire
